// File: rtl/axi4_pkg.sv
// Shared AXI4 constants, refill FSM state type and size helper.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } refill_state_e;

    // AxSIZE encoding for a full-width beat of a data_w-bit bus.
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/line_assembler.sv
// Collects R beats into a line buffer, tracks sticky error and last-beat detection.
// One beat per cycle when beat_i is high; done_o is combinational on the final beat.
module line_assembler
    import axi4_pkg::*;
#(
    parameter int         DATA_W     = 64,
    parameter int         LINE_BEATS = 4,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         beat_i,
    input  logic [DATA_W-1:0]            rdata_i,
    input  logic [1:0]                   rresp_i,
    input  logic [3:0]                   rid_i,
    input  logic                         rlast_i,
    output logic [LINE_BEATS*DATA_W-1:0] line_o,
    output logic                         err_o,
    output logic                         done_o
);

    localparam int               CNT_W     = $clog2(LINE_BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(LINE_BEATS - 1);

    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         err_q, err_d;
    logic [LINE_BEATS*DATA_W-1:0] line_q;
    logic [LINE_BEATS-1:0]        slot_we;
    logic                         at_last;
    logic                         beat_err;

    assign at_last = (cnt_q == LAST_SLOT);
    // rlast must coincide exactly with the final slot; either mismatch is a protocol error.
    assign beat_err = (rresp_i != RESP_OKAY) || (rid_i != AXI_ID) || (rlast_i != at_last);
    assign done_o   = beat_i && (rlast_i || at_last);

    always_comb begin
        slot_we = '0;
        for (int i = 0; i < LINE_BEATS; i++) begin
            slot_we[i] = beat_i && (cnt_q == CNT_W'(i));
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (clear_i) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (beat_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            err_d = err_q | beat_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            for (int i = 0; i < LINE_BEATS; i++) begin
                if (slot_we[i]) line_q[i*DATA_W +: DATA_W] <= rdata_i;
            end
        end
    end

    assign line_o = line_q;
    assign err_o  = err_q;

endmodule

// File: rtl/axi4_line_refill.sv
// AXI4 read master: one INCR burst per line-fill request, whole line returned with error flag.
// Zero-wait latency LINE_BEATS+2 cycles; one request outstanding, AR/R/resp all valid-ready.
module axi4_line_refill
    import axi4_pkg::*;
#(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 64,
    parameter int         LINE_BEATS = 4,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [LINE_BEATS*DATA_W-1:0] resp_line,
    output logic                         resp_err,
    output logic [ADDR_W-1:0]            araddr,
    output logic [3:0]                   arid,
    output logic [7:0]                   arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    output logic                         arvalid,
    input  logic                         arready,
    input  logic [3:0]                   rid,
    input  logic [DATA_W-1:0]            rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready
);

    localparam int              OFF_W     = $clog2(LINE_BEATS * DATA_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    refill_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              clear;
    logic              beat;
    logic              done;
    logic              err;
    logic [LINE_BEATS*DATA_W-1:0] line;

    // Beat qualified from state, not rready, to keep the FSM free of a comb loop.
    assign beat = rvalid && (state_q == DATA);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        clear      = 1'b0;
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr & LINE_MASK;
                    clear   = 1'b1;
                    state_d = AR;
                end
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) state_d = DATA;
            end
            DATA: begin
                rready = 1'b1;
                if (done) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    line_assembler #(
        .DATA_W     (DATA_W),
        .LINE_BEATS (LINE_BEATS),
        .AXI_ID     (AXI_ID)
    ) u_asm (
        .clk     (aclk),
        .rst     (areset),
        .clear_i (clear),
        .beat_i  (beat),
        .rdata_i (rdata),
        .rresp_i (rresp),
        .rid_i   (rid),
        .rlast_i (rlast),
        .line_o  (line),
        .err_o   (err),
        .done_o  (done)
    );

    assign araddr    = addr_q;
    assign arid      = AXI_ID;
    assign arlen     = 8'(LINE_BEATS - 1);
    assign arsize    = axi_size(DATA_W);
    assign arburst   = BURST_INCR;
    assign resp_line = line;
    assign resp_err  = err;

endmodule

// File: doc/axi4_line_refill.md
Name: axi4_line_refill

Overview:
- AXI4 read-only burst master that refills one cache line per request.
- Accepts a line-fill request from the cache side and issues a single INCR burst on AR.
- Collects LINE_BEATS beats from R into a line buffer, then returns the whole line with an error flag.
- Sits directly upstream of the simulated SRAM slave's AR/R channels. The AW/W/B channels are driven elsewhere.

Parameters:
- ADDR_W, 32, address width of req_addr and araddr
- DATA_W, 64, AXI data width; arsize = log2(DATA_W/8) = 3
- LINE_BEATS, 4, beats per line (power of 2, 1..16); arlen = LINE_BEATS-1
- AXI_ID, 4'd0, constant ID driven on arid

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- req_valid  in  1  line-fill request valid
- req_ready  out  1  block idle, request accepted on req_valid&&req_ready
- req_addr  in  ADDR_W  any byte address inside the target line
- resp_valid  out  1  line data valid
- resp_ready  in  1  cache accepts line
- resp_line  out  LINE_BEATS*DATA_W  beat i at bits [i*DATA_W +: DATA_W]
- resp_err  out  1  refill had a bus or protocol error
- araddr  out  ADDR_W  line-aligned burst address
- arid  out  4  AXI_ID
- arlen  out  8  LINE_BEATS-1
- arsize  out  3  log2(DATA_W/8)
- arburst  out  2  2'b01 (INCR)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  read ID
- rdata  in  DATA_W  read beat data
- rresp  in  2  read response
- rlast  in  1  last beat
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Reset (async, areset=1): state IDLE; beat counter = 0; err = 0; line buffer = 0.
  - Outputs: arvalid=0, rready=0, resp_valid=0, resp_err=0, araddr=0, req_ready=1 after reset release.
- arid, arlen, arsize and arburst are constants, valid in every state.
- Alignment: araddr = req_addr with the low log2(LINE_BEATS*DATA_W/8) bits cleared. It is registered at request acceptance and held stable while arvalid=1.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, latch the aligned address, clear err and the counter, go to AR.
  - AR: arvalid=1 from the first cycle after acceptance. arvalid must not drop until arready. On arvalid&&arready, go to DATA. arready may already be high when arvalid rises.
  - DATA: rready=1. Each rvalid&&rready beat writes rdata to slot cnt, then cnt increments.
    - Sticky err is set if rresp!=0, or rid!=AXI_ID, or rlast=1 with cnt<LINE_BEATS-1, or rlast=0 with cnt==LINE_BEATS-1.
    - Leave DATA on the beat with rlast=1 or cnt==LINE_BEATS-1, whichever comes first. Unfilled slots keep their stale data.
  - RESP: resp_valid=1. resp_line and resp_err are stable until resp_ready. On handshake, go to IDLE.
- No back-to-back overlap: a new request is accepted only in IDLE, so at most one outstanding burst.
- Minimum latency, zero-wait slave: accept at cycle 0; arvalid at cycle 1; first beat at cycle 2; resp_valid at cycle LINE_BEATS+2.
- Beats arriving outside DATA are ignored (rready=0).
- Reset mid-burst: immediate return to IDLE with all outputs at reset values. Draining the in-flight burst is not this block's responsibility.
- Counter width: $clog2(LINE_BEATS)+1 bits; it never wraps within a burst.

Decomposition:
- Shared package axi4_pkg holds:
  - burst type constants: BURST_FIXED, BURST_INCR, BURST_WRAP
  - response constants: RESP_OKAY, RESP_SLVERR, RESP_DECERR
  - the refill FSM state enum: IDLE, AR, DATA, RESP
  - an ADDR_W/DATA_W-derived size function
- One natural sub-module, line_assembler: beat counter, slot write-enable decode, line buffer, and the err and last-beat detection logic. The top level holds the FSM and the AR/request/response handshakes.

Test Plan:
- Basic refill: req_addr=0x8000_0038, slave returns 0x11..,0x22..,0x33..,0x44.. with zero wait.
  - araddr=0x8000_0020, arlen=3, arsize=3, arburst=1.
  - resp_line beats 0..3 in order; resp_err=0; resp_valid at cycle 6.
- AR backpressure: arready held low 5 cycles.
  - arvalid and araddr stay stable throughout; exactly one AR handshake; data is correct.
- R gaps and resp stall: rvalid toggled 1,0,0,1,..., then resp_ready held low 3 cycles.
  - All 4 beats captured in order; resp_line and resp_err held unchanged until resp_ready.
- Errors:
  - rresp=2'b10 on beat 2 → resp_err=1 with all 4 beats returned.
  - Separate run: rlast on beat 1 → resp_valid after 2 beats, resp_err=1.
- Reset mid-burst: areset asserted after beat 1.
  - arvalid=rready=resp_valid=0 immediately; a next request 0x1000 completes cleanly with resp_err=0.
- LINE_BEATS=1 build: arlen=0; a single beat with rlast=1 completes with resp_err=0.
